popcnt_stream: RTL and testbench
================================

Name: popcnt_stream

Overview:
- Streaming, parametrised ones-counter and the successor to the fixed 8-bit full-adder popcount.
- Accepts DATA_W-bit words on a valid/ready input and counts set bits with a full-adder tree. The tree result is registered.
- Two modes:
  - per-word mode returns one count per word;
  - frame mode sums counts across a frame and returns one total on the last beat.
- Sits between a stream source and any consumer needing bit-density or weight statistics.

Parameters:
- DATA_W, 8, input word width (>=2).
- ACC_W, 16, width of output count and frame accumulator (>= clog2(DATA_W+1)).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- mode  in  1  0 = per-word, 1 = frame accumulate; sampled only on the first beat of a frame.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  DATA_W  word to count.
- in_last  in  1  last beat of frame; ignored in per-word mode.
- out_valid  out  1  out_count valid.
- out_ready  in  1  consumer accepts.
- out_count  out  ACC_W  ones count, zero-extended.
- out_ovf  out  1  frame sum wrapped past 2^ACC_W-1.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_count=0, out_ovf=0.
  - Stage-1 valid=0; FSM=IDLE; accumulator=0.
  - in_ready is 0 while rst_n=0.
  - A reset mid-frame discards the partial sum. No output is produced for it.
- Global advance: adv = !out_valid || out_ready.
  - in_ready = adv, a combinational path from out_ready, documented.
  - A beat is accepted when in_valid && in_ready.
- Stage 1, registered on adv:
  - s1_cnt = popcount(in_data), width WC_W = clog2(DATA_W+1).
  - s1_valid = accepted; s1_last and s1_mode are captured.
- Stage 2 / FSM, acting on adv && s1_valid:
  - IDLE, s1_mode=0: out_count <= s1_cnt, out_valid <= 1, out_ovf <= 0. Stay IDLE.
  - IDLE, s1_mode=1, s1_last=1: single-beat frame. Output s1_cnt, stay IDLE.
  - IDLE, s1_mode=1, s1_last=0: acc <= s1_cnt, ovf <= 0. Go to ACC.
  - ACC, s1_last=0: acc <= acc + s1_cnt, modulo 2^ACC_W. ovf is set sticky on carry-out.
  - ACC, s1_last=1: out_count <= acc + s1_cnt; out_ovf <= ovf | carry; out_valid <= 1. Go to IDLE.
  - In ACC, mode is ignored. The mode latched at frame start holds until in_last.
- Latency:
  - out_valid rises 2 cycles after acceptance of a per-word beat or of the frame's last beat.
  - Full throughput of 1 word/cycle when out_ready=1.
- Output hold: while out_valid && !out_ready:
  - out_count and out_ovf are stable;
  - stage 1 and the accumulator freeze;
  - in_ready=0.
- Output clear: when out_valid && out_ready && no new result, out_valid <= 0 next cycle.
- Boundaries:
  - in_data all-zero gives count 0, still reported.
  - All-ones gives DATA_W.
  - Back-to-back frames with no gap are legal.

Optional Feature:
- POPCNT_PARITY_EN.
- When defined: adds output out_parity (1 bit) = LSB of the unwrapped sum, i.e. XOR of all counted bits. Registered with out_count; reset value 0; same hold rules.
- When undefined: the port and its logic are absent.

Decomposition:
- Package popcnt_pkg:
  - function cnt_w(n) = clog2(n+1);
  - FSM state enum {IDLE, ACC};
  - mode encodings MODE_WORD=0, MODE_FRAME=1.
- Sub-module popcnt_csa, parametrised by DATA_W: purely combinational carry-save tree built only from existing full_adder instances, with a final ripple stage. Output is WC_W bits.
- Top level holds the registers, the FSM and the handshake.

Test Plan:
- Per-word, DATA_W=8, out_ready=1: in_data 8'b11011011, then 8'hFF, then 8'h00 -> out_count 6, 8, 0 on cycles 2, 3, 4 after the first accept.
- Frame mode: beats 8'h0F, 8'hF0, 8'h01 (last) -> single output 9, out_ovf=0. No out_valid on non-last beats.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> out_count stable, in_ready=0, no beats lost. Releasing gives the next counts in order.
- Overflow, ACC_W=4, DATA_W=8: frame of 8'hFF, 8'hFF, 8'h03 (last) -> out_count 18 mod 16 = 2, out_ovf=1.
- Reset mid-frame: assert rst_n=0 after 2 frame beats -> all outputs 0 immediately. Next per-word 8'h07 -> out_count 3.
- With POPCNT_PARITY_EN: frame 8'h01, 8'h03 (last) -> out_count 3, out_parity 1.

Source files
------------

// File: rtl/popcnt_pkg.sv
// Shared types and helpers for the streaming ones-counter.
package popcnt_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  localparam logic MODE_WORD  = 1'b0;
  localparam logic MODE_FRAME = 1'b1;

  // Bits needed to hold a count of 0..n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder; the only arithmetic cell used by the counting tree.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

// File: rtl/popcnt_csa.sv
// Combinational ones-counter: binary tree of carry-save pairs built from
// full adders, resolved by a final ripple stage.
module popcnt_csa import popcnt_pkg::*; #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0]         i_data,
  output logic [cnt_w(DATA_W)-1:0]  o_cnt
);
  localparam int WC_W   = cnt_w(DATA_W);
  localparam int LEAVES = 1 << $clog2(DATA_W);

  // Heap-indexed nodes: node n merges children 2n and 2n+1. Every node holds
  // its partial count as a (sum, carry) pair; carries past WC_W are dropped
  // because the true total never exceeds DATA_W.
  for (genvar n = 1; n < 2*LEAVES; n++) begin : g_node
    logic [WC_W-1:0] w_s;
    logic [WC_W-1:0] w_c;
    if (n >= LEAVES) begin : g_leaf
      if (n - LEAVES < DATA_W) begin : g_bit
        assign w_s = WC_W'(i_data[n-LEAVES]);
      end else begin : g_pad
        assign w_s = '0;
      end
      assign w_c = '0;
    end else begin : g_merge
      logic [WC_W-1:0] w_s1;
      logic [WC_W-1:0] w_cy1;
      logic [WC_W-1:0] w_c1;
      logic [WC_W-1:0] w_cy2;
      logic            w_unused_top;
      assign w_c1 = {w_cy1[WC_W-2:0], 1'b0};
      for (genvar b = 0; b < WC_W; b++) begin : g_bit
        full_adder u_fa1 (
          .i_a   (g_node[2*n].w_s[b]),
          .i_b   (g_node[2*n].w_c[b]),
          .i_cin (g_node[2*n+1].w_s[b]),
          .o_sum (w_s1[b]),
          .o_cout(w_cy1[b])
        );
        full_adder u_fa2 (
          .i_a   (w_s1[b]),
          .i_b   (w_c1[b]),
          .i_cin (g_node[2*n+1].w_c[b]),
          .o_sum (w_s[b]),
          .o_cout(w_cy2[b])
        );
      end
      assign w_c          = {w_cy2[WC_W-2:0], 1'b0};
      assign w_unused_top = w_cy1[WC_W-1] ^ w_cy2[WC_W-1];
    end
  end

  for (genvar b = 0; b < WC_W; b++) begin : g_rip
    logic w_ci;
    logic w_co;
    if (b == 0) begin : g_lsb
      assign w_ci = 1'b0;
    end else begin : g_up
      assign w_ci = g_rip[b-1].w_co;
    end
    full_adder u_fa (
      .i_a   (g_node[1].w_s[b]),
      .i_b   (g_node[1].w_c[b]),
      .i_cin (w_ci),
      .o_sum (o_cnt[b]),
      .o_cout(w_co)
    );
  end

  logic w_unused_co;
  assign w_unused_co = g_rip[WC_W-1].w_co;

endmodule

// File: rtl/popcnt_stream.sv
// Streaming ones-counter: per-word counts or per-frame sums on valid/ready.
// Define POPCNT_PARITY_EN to add out_parity (LSB of the unwrapped sum).
module popcnt_stream import popcnt_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_count,
  output logic              out_ovf
`ifdef POPCNT_PARITY_EN
  ,
  output logic              out_parity
`endif
);
  localparam int WC_W = cnt_w(DATA_W);

  // Wrapping accumulate; the top bit is the carry-out.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                             input logic [WC_W-1:0]  c);
    return {1'b0, a} + (ACC_W+1)'(c);
  endfunction

  logic             w_adv;
  logic             w_accept;
  logic [WC_W-1:0]  w_cnt_p0;
  logic [ACC_W:0]   w_sum_p1;

  logic [WC_W-1:0]  r_cnt_p1;
  logic             r_last_p1;
  logic             r_mode_p1;
  logic             r_vld_p1;
  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic             r_out_vld;
  logic [ACC_W-1:0] r_out_cnt;
  logic             r_out_ovf;
`ifdef POPCNT_PARITY_EN
  logic             r_par;
  logic             r_out_par;
`endif

  // in_ready is combinational from out_ready through the advance term.
  assign w_adv    = !r_out_vld || out_ready;
  assign in_ready = rst_n && w_adv;
  assign w_accept = in_valid && in_ready;

  popcnt_csa #(.DATA_W(DATA_W)) u_csa (
    .i_data(in_data),
    .o_cnt (w_cnt_p0)
  );

  // ---- stage 0 -> stage 1: registered tree result ----
  always_ff @(posedge clk) begin
    if (in_valid && w_adv) begin
      r_cnt_p1  <= w_cnt_p0;
      r_last_p1 <= in_last;
      r_mode_p1 <= mode;
    end
  end

  assign w_sum_p1 = acc_add(r_acc, r_cnt_p1);

  // ---- stage 1 -> stage 2: frame FSM and output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1  <= 1'b0;
      r_state   <= IDLE;
      r_acc     <= '0;
      r_ovf     <= 1'b0;
      r_out_vld <= 1'b0;
      r_out_cnt <= '0;
      r_out_ovf <= 1'b0;
`ifdef POPCNT_PARITY_EN
      r_par     <= 1'b0;
      r_out_par <= 1'b0;
`endif
    end else if (w_adv) begin
      r_vld_p1  <= w_accept;
      r_out_vld <= 1'b0;
      if (r_vld_p1) begin
        case (r_state)
          IDLE: begin
            if (r_mode_p1 == MODE_WORD || r_last_p1) begin
              r_out_vld <= 1'b1;
              r_out_cnt <= ACC_W'(r_cnt_p1);
              r_out_ovf <= 1'b0;
`ifdef POPCNT_PARITY_EN
              r_out_par <= r_cnt_p1[0];
`endif
            end else begin
              r_acc   <= ACC_W'(r_cnt_p1);
              r_ovf   <= 1'b0;
`ifdef POPCNT_PARITY_EN
              r_par   <= r_cnt_p1[0];
`endif
              r_state <= ACC;
            end
          end
          ACC: begin
            if (r_last_p1) begin
              r_out_vld <= 1'b1;
              r_out_cnt <= w_sum_p1[ACC_W-1:0];
              r_out_ovf <= r_ovf | w_sum_p1[ACC_W];
`ifdef POPCNT_PARITY_EN
              r_out_par <= r_par ^ r_cnt_p1[0];
`endif
              r_state   <= IDLE;
            end else begin
              r_acc <= w_sum_p1[ACC_W-1:0];
              r_ovf <= r_ovf | w_sum_p1[ACC_W];
`ifdef POPCNT_PARITY_EN
              r_par <= r_par ^ r_cnt_p1[0];
`endif
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign out_valid = r_out_vld;
  assign out_count = r_out_cnt;
  assign out_ovf   = r_out_ovf;
`ifdef POPCNT_PARITY_EN
  assign out_parity = r_out_par;
`endif

endmodule

// File: tb/tb_popcnt_stream.sv
// Bench for popcnt_stream: directed table, hand-timed sequences and random
// traffic against a transaction-level model; two instances (ACC_W 16 and 4).
module tb_popcnt_stream;

  typedef struct {
    int cnt;
    bit ovf;
    bit par;
  } exp_t;

  typedef struct {
    logic       m;
    logic [7:0] d;
    logic       l;
    bit         o;
    int         cnt;
    bit         ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_ready;
  logic        in_ready, out_valid, out_ovf;
  logic [15:0] out_count;
  logic        in_ready_o, out_valid_o, out_ovf_o;
  logic [3:0]  out_count_o;
`ifdef POPCNT_PARITY_EN
  logic        out_parity, out_parity_o;
`endif

  always #5 clk = ~clk;

  popcnt_stream #(.DATA_W(8), .ACC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
    .out_ovf(out_ovf)
`ifdef POPCNT_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  popcnt_stream #(.DATA_W(8), .ACC_W(4)) dut_o (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready_o), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_o), .out_ready(out_ready), .out_count(out_count_o),
    .out_ovf(out_ovf_o)
`ifdef POPCNT_PARITY_EN
    , .out_parity(out_parity_o)
`endif
  );

  int   n_vec = 0;
  int   n_err = 0;
  exp_t q16[$];
  exp_t q4[$];
  exp_t e16, e4;
  bit   fr_act = 1'b0;
  int   fr_sum = 0;
  bit   prev_hold = 1'b0;
  bit   rnd_bp = 1'b0;
  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  // Frame-level reference: total ones across the frame as a plain integer.
  function automatic void model_accept(input logic m, input logic [7:0] d,
                                       input logic l, input bit tb,
                                       input bit t_out, input int t_cnt,
                                       input bit t_ovf);
    int c;
    int s;
    bit done;
    c = $countones(d);
    s = 0;
    done = 1'b0;
    if (!fr_act) begin
      if (m == 1'b0 || l) begin
        done = 1'b1;
        s = c;
      end else begin
        fr_act = 1'b1;
        fr_sum = c;
      end
    end else begin
      fr_sum = fr_sum + c;
      if (l) begin
        done = 1'b1;
        s = fr_sum;
        fr_act = 1'b0;
      end
    end
    if (done) q4.push_back('{s % 16, s >= 16, s[0]});
    if (done && !tb) q16.push_back('{s % 65536, s >= 65536, s[0]});
    if (tb && t_out) q16.push_back('{t_cnt, t_ovf, t_cnt[0]});
  endfunction

  task automatic send(input logic m, input logic [7:0] d, input logic l,
                      input bit tb, input bit t_out, input int t_cnt,
                      input bit t_ovf);
    int g;
    g = 0;
    mode = m;
    in_data = d;
    in_last = l;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && g < 200) begin
      g++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: in_ready=0 for %0d cycles, required 1", g);
    end else begin
      model_accept(m, d, l, tb, t_out, t_cnt, t_ovf);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((q16.size() != 0 || q4.size() != 0) && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("drain_outstanding", q16.size() + q4.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: every handshake must match the next expected result.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) chk("hold_valid", out_valid, 1);
      if (out_valid && !out_ready) begin
        chk("hold_in_ready", in_ready, 0);
        if (q16.size() != 0) chk("hold_count", out_count, q16[0].cnt);
      end
      if (out_valid && out_ready) begin
        if (q16.size() == 0) begin
          chk("out16_spurious", out_count, -1);
        end else begin
          e16 = q16.pop_front();
          chk("out16_count", out_count, e16.cnt);
          chk("out16_ovf", out_ovf, e16.ovf);
`ifdef POPCNT_PARITY_EN
          chk("out16_parity", out_parity, e16.par);
`endif
        end
      end
      if (out_valid_o && out_ready) begin
        if (q4.size() == 0) begin
          chk("out4_spurious", out_count_o, -1);
        end else begin
          e4 = q4.pop_front();
          chk("out4_count", out_count_o, e4.cnt);
          chk("out4_ovf", out_ovf_o, e4.ovf);
`ifdef POPCNT_PARITY_EN
          chk("out4_parity", out_parity_o, e4.par);
`endif
        end
      end
      prev_hold = out_valid && !out_ready;
    end
  end

  always @(posedge clk) begin
    if (rnd_bp) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    mode = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    in_last = 1'b0;
    out_ready = 1'b1;

    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_in_ready_o", in_ready_o, 0);
`ifdef POPCNT_PARITY_EN
    chk("rst_out_parity", out_parity, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Per-word latency and back-to-back throughput
    fork
      begin
        send(1'b0, 8'b11011011, 1'b0, 1'b1, 1'b1, 6, 1'b0);
        send(1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 8, 1'b0);
        send(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 0, 1'b0);
      end
      begin
        @(posedge clk);
        @(negedge clk);
        chk("lat_early_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_valid0", out_valid, 1);
        chk("lat_count0", out_count, 6);
        @(negedge clk);
        chk("lat_count1", out_count, 8);
        @(negedge clk);
        chk("lat_valid2", out_valid, 1);
        chk("lat_count2", out_count, 0);
      end
    join
    drain();

    // Directed table: per-word, frames, mode ignored mid-frame, wrap frames
    tbl.push_back('{1'b0, 8'hDB, 1'b0, 1'b1, 6, 1'b0});
    tbl.push_back('{1'b0, 8'hFF, 1'b1, 1'b1, 8, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0});
    tbl.push_back('{1'b1, 8'h0F, 1'b0, 1'b0, 0, 1'b0});
    tbl.push_back('{1'b0, 8'hF0, 1'b0, 1'b0, 0, 1'b0});
    tbl.push_back('{1'b0, 8'h01, 1'b1, 1'b1, 9, 1'b0});
    tbl.push_back('{1'b1, 8'hAA, 1'b1, 1'b1, 4, 1'b0});
    tbl.push_back('{1'b1, 8'hFF, 1'b0, 1'b0, 0, 1'b0});
    tbl.push_back('{1'b1, 8'hFF, 1'b0, 1'b0, 0, 1'b0});
    tbl.push_back('{1'b1, 8'h03, 1'b1, 1'b1, 18, 1'b0});
    tbl.push_back('{1'b1, 8'hFF, 1'b0, 1'b0, 0, 1'b0});
    tbl.push_back('{1'b1, 8'hFF, 1'b1, 1'b1, 16, 1'b0});
    tbl.push_back('{1'b1, 8'h0F, 1'b0, 1'b0, 0, 1'b0});
    tbl.push_back('{1'b1, 8'h03, 1'b1, 1'b1, 6, 1'b0});
    tbl.push_back('{1'b1, 8'h01, 1'b0, 1'b0, 0, 1'b0});
    tbl.push_back('{1'b1, 8'h03, 1'b1, 1'b1, 3, 1'b0});
    tbl.push_back('{1'b0, 8'h80, 1'b0, 1'b1, 1, 1'b0});
    for (int i = 0; i < tbl.size(); i++) begin
      send(tbl[i].m, tbl[i].d, tbl[i].l, 1'b1, tbl[i].o, tbl[i].cnt, tbl[i].ovf);
    end
    drain();

    // Backpressure: output held for several cycles, nothing lost
    out_ready = 1'b0;
    fork
      begin
        send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        send(1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        send(1'b0, 8'hFE, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      end
      begin
        repeat (7) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset in the middle of a frame discards the partial sum
    send(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    send(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_count", out_count, 0);
    chk("mid_rst_out_ovf", out_ovf, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_count_o", out_count_o, 0);
    q16.delete();
    q4.delete();
    fr_act = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(1'b0, 8'h07, 1'b0, 1'b1, 1'b1, 3, 1'b0);
    drain();

    // Random traffic with random gaps and backpressure
    rnd_bp = 1'b1;
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [7:0] d;
      r = $urandom_range(0, 7);
      d = (r == 0) ? 8'hFF : (r == 1) ? 8'h00 : 8'($urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(1'($urandom), d, ($urandom_range(0, 2) == 0), 1'b0, 1'b0, 0, 1'b0);
    end
    send(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    rnd_bp = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
